// File: rtl/accum_s1_ctrl.sv
// Strategy-1 accumulator sequencer: walks every output block of every K-tile,
// reloading the stored partial sum and writing back the accumulated result.
module accum_s1_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned TILE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [TILE_W-1:0] i_num_k_tiles,
    input  logic [ADDR_W-1:0] i_num_blocks,
    input  logic              i_result_valid,
    output logic              o_result_ready,
    output logic              o_psum_rd_en,
    output logic [ADDR_W-1:0] o_psum_rd_addr,
    output logic              o_psum_zero,
    output logic              o_accumulation,
    output logic              o_strategy_1_en,
    output logic              o_psum_wr_en,
    output logic [ADDR_W-1:0] o_psum_wr_addr,
    output logic              o_final,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD,
        S_RES,
        S_WB,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] blk_q, blk_d;
    logic [TILE_W-1:0] kt_q, kt_d;
    logic [ADDR_W-1:0] num_blk_q, num_blk_d;
    logic [TILE_W-1:0] num_kt_q, num_kt_d;
    logic              last_blk;
    logic              last_kt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            blk_q     <= '0;
            kt_q      <= '0;
            num_blk_q <= '0;
            num_kt_q  <= '0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            kt_q      <= kt_d;
            num_blk_q <= num_blk_d;
            num_kt_q  <= num_kt_d;
        end
    end

    // Counts are nonzero whenever these compares matter (zero counts skip to DONE).
    always_comb begin
        last_blk = (blk_q == (num_blk_q - ADDR_W'(1)));
        last_kt  = (kt_q == (num_kt_q - TILE_W'(1)));
    end

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        kt_d      = kt_q;
        num_blk_d = num_blk_q;
        num_kt_d  = num_kt_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    num_blk_d = i_num_blocks;
                    num_kt_d  = i_num_k_tiles;
                    blk_d     = '0;
                    kt_d      = '0;
                    if ((i_num_blocks == '0) || (i_num_k_tiles == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:  state_d = S_LD;
            S_LD:  state_d = S_RES;
            S_RES: begin
                if (i_result_valid) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (last_blk) begin
                    blk_d = '0;
                    if (last_kt) begin
                        state_d = S_DONE;
                    end else begin
                        kt_d    = kt_q + TILE_W'(1);
                        state_d = S_RD;
                    end
                end else begin
                    blk_d   = blk_q + ADDR_W'(1);
                    state_d = S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_result_ready  = 1'b0;
        o_psum_rd_en    = 1'b0;
        o_psum_rd_addr  = '0;
        o_psum_zero     = 1'b0;
        o_accumulation  = 1'b0;
        o_strategy_1_en = 1'b0;
        o_psum_wr_en    = 1'b0;
        o_psum_wr_addr  = '0;
        o_final         = 1'b0;
        o_busy          = (state_q != S_IDLE);
        o_done          = 1'b0;
        unique case (state_q)
            S_RD: begin
                o_psum_rd_en   = 1'b1;
                o_psum_rd_addr = blk_q;
            end
            S_LD: begin
                o_accumulation = 1'b1;
                o_psum_zero    = (kt_q == '0);
            end
            S_RES: begin
                o_result_ready  = 1'b1;
                o_strategy_1_en = i_result_valid;
            end
            S_WB: begin
                o_psum_wr_en   = 1'b1;
                o_psum_wr_addr = blk_q;
                o_final        = last_kt;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_accum_s1_ctrl.sv
// Bench for accum_s1_ctrl: expected read/load/write events are queued at start
// and popped by a monitor as the sequencer produces them.
module tb_accum_s1_ctrl;
    localparam int unsigned AW = 8;
    localparam int unsigned TW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] nk = '0;
    logic [AW-1:0] nb = '0;
    logic          valid = 1'b0;

    logic          o_result_ready, o_psum_rd_en, o_psum_zero, o_accumulation;
    logic          o_strategy_1_en, o_psum_wr_en, o_final, o_busy, o_done;
    logic [AW-1:0] o_psum_rd_addr, o_psum_wr_addr;
    logic [2*AW+8:0] allout;

    int errors = 0;
    int checks = 0;
    int stall_n = 0;
    int stall_cnt = 0;
    bit mon_en = 1'b0;

    logic [AW-1:0] rd_q[$];
    bit            ld_q[$];
    logic [AW:0]   wr_q[$];

    accum_s1_ctrl #(.ADDR_W(AW), .TILE_W(TW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_num_k_tiles(nk), .i_num_blocks(nb), .i_result_valid(valid),
        .o_result_ready(o_result_ready), .o_psum_rd_en(o_psum_rd_en),
        .o_psum_rd_addr(o_psum_rd_addr), .o_psum_zero(o_psum_zero),
        .o_accumulation(o_accumulation), .o_strategy_1_en(o_strategy_1_en),
        .o_psum_wr_en(o_psum_wr_en), .o_psum_wr_addr(o_psum_wr_addr),
        .o_final(o_final), .o_busy(o_busy), .o_done(o_done)
    );

    assign allout = {o_result_ready, o_psum_rd_en, o_psum_rd_addr, o_psum_zero,
                     o_accumulation, o_strategy_1_en, o_psum_wr_en, o_psum_wr_addr,
                     o_final, o_busy, o_done};

    always #5 clk = ~clk;

    // Result-valid source: always high, or withheld stall_n cycles per RES visit.
    always @(negedge clk) begin
        if (stall_n == 0) begin
            valid = 1'b1;
        end else if (o_result_ready) begin
            if (stall_cnt >= stall_n) valid = 1'b1;
            else stall_cnt++;
        end else begin
            valid = 1'b0;
            stall_cnt = 0;
        end
    end

    always @(negedge clk) begin
        logic [AW-1:0] ea;
        bit            ez;
        logic [AW:0]   ew;
        if (mon_en && rst_n) begin
            checks++;
            if (o_psum_rd_en) begin
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got read addr %0d, required no read", o_psum_rd_addr);
                end else begin
                    ea = rd_q.pop_front();
                    if (o_psum_rd_addr !== ea) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d, required %0d", o_psum_rd_addr, ea);
                    end
                end
            end else if (o_psum_rd_addr !== '0) begin
                errors++;
                $display("FAIL rd_addr_idle: got %0d, required 0", o_psum_rd_addr);
            end
            checks++;
            if (o_accumulation) begin
                if (ld_q.size() == 0) begin
                    errors++;
                    $display("FAIL ld_unexpected: got load, required none");
                end else begin
                    ez = ld_q.pop_front();
                    if (o_psum_zero !== ez) begin
                        errors++;
                        $display("FAIL psum_zero: got %b, required %b", o_psum_zero, ez);
                    end
                end
            end else if (o_psum_zero !== 1'b0) begin
                errors++;
                $display("FAIL psum_zero_idle: got %b, required 0", o_psum_zero);
            end
            checks++;
            if (o_psum_wr_en) begin
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got write addr %0d, required no write", o_psum_wr_addr);
                end else begin
                    ew = wr_q.pop_front();
                    if ({o_final, o_psum_wr_addr} !== ew) begin
                        errors++;
                        $display("FAIL wr_final_addr: got final=%b addr=%0d, required final=%b addr=%0d",
                                 o_final, o_psum_wr_addr, ew[AW], ew[AW-1:0]);
                    end
                end
            end else if ({o_final, o_psum_wr_addr} !== '0) begin
                errors++;
                $display("FAIL wr_idle: got final=%b addr=%0d, required 0", o_final, o_psum_wr_addr);
            end
            checks++;
            if (o_result_ready && !valid) begin
                if ({o_strategy_1_en, o_psum_wr_en, o_psum_rd_en, o_accumulation} !== 4'b0) begin
                    errors++;
                    $display("FAIL stall_strobes: got s1/wr/rd/acc=%b, required 0000",
                             {o_strategy_1_en, o_psum_wr_en, o_psum_rd_en, o_accumulation});
                end
            end else if (o_strategy_1_en && !(o_result_ready && valid)) begin
                errors++;
                $display("FAIL s1_en_outside_res: got 1, required 0");
            end
        end
    end

    task automatic push_expect(input int k, input int n);
        for (int kt = 0; kt < k; kt++) begin
            for (int b = 0; b < n; b++) begin
                rd_q.push_back(AW'(b));
                ld_q.push_back(kt == 0);
                wr_q.push_back({(kt == k - 1), AW'(b)});
            end
        end
    endtask

    // Returns at the negedge of the cycle after acceptance (T+1); counts are
    // then scrambled to prove they were latched.
    task automatic start_op(input int k, input int n);
        @(negedge clk);
        start = 1'b1;
        nk = TW'(k);
        nb = AW'(n);
        @(negedge clk);
        start = 1'b0;
        nk = 8'hA5;
        nb = 8'h5A;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (o_done !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if (allout !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", allout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (allout !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got %h, required 0", allout);
        end
    endtask

    task automatic test_single();
        push_expect(1, 1);
        start_op(1, 1);
        checks++;
        if (o_psum_rd_en !== 1'b1) begin
            errors++; $display("FAIL single_rd_t1: got %b, required 1", o_psum_rd_en);
        end
        @(negedge clk);
        checks++;
        if ({o_accumulation, o_psum_zero} !== 2'b11) begin
            errors++; $display("FAIL single_ld_t2: got acc/zero=%b, required 11", {o_accumulation, o_psum_zero});
        end
        @(negedge clk);
        checks++;
        if (o_strategy_1_en !== 1'b1) begin
            errors++; $display("FAIL single_s1_t3: got %b, required 1", o_strategy_1_en);
        end
        @(negedge clk);
        checks++;
        if ({o_psum_wr_en, o_final, o_psum_wr_addr} !== {2'b11, 8'd0}) begin
            errors++; $display("FAIL single_wr_t4: got wr=%b final=%b addr=%0d, required 1 1 0",
                               o_psum_wr_en, o_final, o_psum_wr_addr);
        end
        @(negedge clk);
        checks++;
        if ({o_done, o_busy} !== 2'b11) begin
            errors++; $display("FAIL single_done_t5: got done/busy=%b, required 11", {o_done, o_busy});
        end
        @(negedge clk);
        checks++;
        if ({o_done, o_busy} !== 2'b00) begin
            errors++; $display("FAIL single_after_done: got done/busy=%b, required 00", {o_done, o_busy});
        end
    endtask

    task automatic test_multi();
        int lat;
        push_expect(3, 4);
        start_op(3, 4);
        wait_done(lat);
        checks++;
        if (lat != 49) begin
            errors++; $display("FAIL multi_latency: got %0d, required 49", lat);
        end
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0 || ld_q.size() != 0) begin
            errors++; $display("FAIL multi_leftover: got %0d writes pending, required 0", wr_q.size());
        end
    endtask

    task automatic test_stall();
        int lat;
        stall_n = 5;
        @(negedge clk);
        @(negedge clk);
        push_expect(2, 2);
        start_op(2, 2);
        wait_done(lat);
        checks++;
        if (lat != 37) begin
            errors++; $display("FAIL stall_latency: got %0d, required 37", lat);
        end
        checks++;
        if (wr_q.size() != 0) begin
            errors++; $display("FAIL stall_leftover: got %0d writes pending, required 0", wr_q.size());
        end
        stall_n = 0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat;
        start_op(0, 4);
        wait_done(lat);
        checks++;
        if (lat != 1) begin
            errors++; $display("FAIL zero_k_latency: got %0d, required 1", lat);
        end
        start_op(3, 0);
        wait_done(lat);
        checks++;
        if (lat != 1) begin
            errors++; $display("FAIL zero_n_latency: got %0d, required 1", lat);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL zero_busy_after: got %b, required 0", o_busy);
        end
    endtask

    task automatic test_midstart();
        int lat;
        push_expect(2, 2);
        start_op(2, 2);
        lat = 1;
        while (o_done !== 1'b1 && lat < 2000) begin
            start = (lat == 3 || lat == 9);
            nk = 8'd5;
            nb = 8'd7;
            @(negedge clk);
            lat++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (lat != 17) begin
            errors++; $display("FAIL midstart_latency: got %0d, required 17", lat);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL start_in_done: got busy=%b, required 0", o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || wr_q.size() != 0) begin
            errors++; $display("FAIL midstart_after: got busy=%b pending=%0d, required 0 0", o_busy, wr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int wr_seen;
        push_expect(2, 3);
        start_op(2, 3);
        wr_seen = 0;
        lat = 0;
        while (wr_seen < 2 && lat < 200) begin
            if (o_psum_wr_en === 1'b1) wr_seen++;
            if (wr_seen < 2) begin
                @(negedge clk);
                lat++;
            end
        end
        checks++;
        if (wr_seen != 2) begin
            errors++; $display("FAIL rstmid_wb_timeout: got %0d writes, required 2", wr_seen);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (allout !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got %h, required 0", allout);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({o_done, o_busy, o_psum_wr_en} !== 3'b000) begin
                errors++; $display("FAIL rstmid_hold: got done/busy/wr=%b, required 000",
                                   {o_done, o_busy, o_psum_wr_en});
            end
        end
        rd_q.delete();
        ld_q.delete();
        wr_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_restart: got busy=%b, required 0", o_busy);
        end
        push_expect(1, 1);
        start_op(1, 1);
        wait_done(lat);
        checks++;
        if (lat != 5) begin
            errors++; $display("FAIL rstmid_restart_latency: got %0d, required 5", lat);
        end
        checks++;
        if (wr_q.size() != 0) begin
            errors++; $display("FAIL rstmid_restart_leftover: got %0d pending, required 0", wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_zero();
        test_midstart();
        test_reset_mid();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
